// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Prefix byte values and the frame FSM state encoding.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_PFX_EXT0  = 8'hE0;
    localparam logic [7:0] PS2_PFX_EXT1  = 8'hE1;
    localparam logic [7:0] PS2_PFX_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    function automatic logic is_ext_prefix(input logic [7:0] b);
        return (b == PS2_PFX_EXT0) || (b == PS2_PFX_EXT1);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line synchroniser, clock glitch filter and 11-bit frame deserialiser.
// Optional partial-frame timeout is built only when PS2_TIMEOUT_EN is defined.
module ps2_rx_frame
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_ok_o,
    output logic       byte_err_o
);

    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_s, data_s;

    logic                   filt_q, filt_d;
    logic [FltW-1:0]        flt_cnt_q, flt_cnt_d;
    logic                   fall;

    ps2_state_e             state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   par_q, par_d;
    logic                   byte_ok_q, byte_ok_d;
    logic                   byte_err_q, byte_err_d;
    logic                   timeout;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Filtered clock only flips once the synchronised line has disagreed for FILTER_LEN samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
        filt_d      = filt_q;
        flt_cnt_d   = '0;
        fall        = 1'b0;
        if (clk_s != filt_q) begin
            if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
                fall   = filt_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FltW'(1);
            end
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        timeout  = 1'b0;
        if (fall || state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES)) begin
            timeout  = 1'b1;
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        byte_ok_d  = 1'b0;
        byte_err_d = 1'b0;
        if (timeout) begin
            state_d    = IDLE;
            byte_err_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // Odd parity over data+parity, and the stop bit must be high.
                    if ((^{shift_q, par_q}) && data_s) byte_ok_d  = 1'b1;
                    else                               byte_err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= 1'b1;
            flt_cnt_q   <= '0;
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            byte_ok_q   <= 1'b0;
            byte_err_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            flt_cnt_q   <= flt_cnt_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_q       <= par_d;
            byte_ok_q   <= byte_ok_d;
            byte_err_q  <= byte_err_d;
        end
    end

    assign byte_o     = shift_q;
    assign byte_ok_o  = byte_ok_q;
    assign byte_err_o = byte_err_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: folds E0/E1/F0 prefixes into flags, one event per key on valid/ready.
// Define PS2_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle clk cycles.
module ps2_kbd_rx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_err,
    output logic       overflow
);

    logic [7:0] rx_byte;
    logic       rx_ok, rx_err;
    logic       emit, accept;

    logic       ext_flag_q, ext_flag_d;
    logic       rel_flag_q, rel_flag_d;
    logic [7:0] code_q, code_d;
    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       ovf_q, ovf_d;

    ps2_rx_frame #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .ps2_clk_i (ps2_kbd_clk),
        .ps2_data_i(ps2_kbd_data),
        .byte_o    (rx_byte),
        .byte_ok_o (rx_ok),
        .byte_err_o(rx_err)
    );

    always_comb begin
        ext_flag_d = ext_flag_q;
        rel_flag_d = rel_flag_q;
        emit       = 1'b0;
        if (rx_err) begin
            ext_flag_d = 1'b0;
            rel_flag_d = 1'b0;
        end else if (rx_ok) begin
            if (is_ext_prefix(rx_byte)) begin
                ext_flag_d = 1'b1;
            end else if (rx_byte == PS2_PFX_BREAK) begin
                rel_flag_d = 1'b1;
            end else begin
                emit       = 1'b1;
                ext_flag_d = 1'b0;
                rel_flag_d = 1'b0;
            end
        end
    end

    // A handshake in the same cycle as an emit frees the slot, so the new event loads with no bubble.
    always_comb begin
        accept  = valid_q & key_ready;
        code_d  = code_q;
        ext_d   = ext_q;
        rel_d   = rel_q;
        valid_d = valid_q;
        err_d   = rx_err;
        ovf_d   = 1'b0;
        if (emit) begin
            if (!valid_q || accept) begin
                code_d  = rx_byte;
                ext_d   = ext_flag_q;
                rel_d   = rel_flag_q;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_flag_q <= 1'b0;
            rel_flag_q <= 1'b0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ext_flag_q <= ext_flag_d;
            rel_flag_q <= rel_flag_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign key_code    = code_q;
    assign key_ext     = ext_q;
    assign key_release = rel_q;
    assign key_valid   = valid_q;
    assign frame_err   = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: scoreboard of expected key events plus per-scenario checks.
// The timeout scenario is compiled only when PS2_TIMEOUT_EN is defined.
module tb_ps2_kbd_rx;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned FILT   = 4;
    localparam int unsigned TO_CYC = 1000;
    localparam int          H      = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_release, key_valid;
    logic       key_ready = 1'b1;
    logic       frame_err, overflow;

    int n_cmp = 0;
    int n_fail = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .SYNC_STAGES   (SYNC),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk         (clk),
        .reset_n     (rst_n),
        .ps2_kbd_clk (ps2_clk),
        .ps2_kbd_data(ps2_data),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    // Scoreboard: every accepted event is popped and compared
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (overflow) ovf_seen++;
            if (key_valid && key_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got code=%h ext=%b rel=%b, required none",
                             key_code, key_ext, key_release);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({key_code, key_ext, key_release} !== e) begin
                        n_fail++;
                        $display("FAIL event: got code=%h ext=%b rel=%b, required code=%h ext=%b rel=%b",
                                 key_code, key_ext, key_release, e[9:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                               input logic stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0, 1'b1), 11);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 key_ready = r;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (key_code !== 8'h00) begin n_fail++; $display("FAIL rst_code: got %h, required 00", key_code); end
        if (key_ext !== 1'b0) begin n_fail++; $display("FAIL rst_ext: got %b, required 0", key_ext); end
        if (key_release !== 1'b0) begin n_fail++; $display("FAIL rst_rel: got %b, required 0", key_release); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", key_valid); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_ferr: got %b, required 0", frame_err); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int e0;
        e0 = err_seen;
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'h1C);
        drain("single");
        @(negedge clk);
        n_cmp += 2;
        if (err_seen != e0) begin n_fail++; $display("FAIL single_ferr: got %0d, required 0", err_seen - e0); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid: got %b, required 0", key_valid); end
    endtask

    task automatic test_prefix();
        exp_q.push_back({8'h75, 1'b1, 1'b1});
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        drain("prefix");
        exp_q.push_back({8'h6B, 1'b1, 1'b0});
        send_byte(8'hE1);
        send_byte(8'h6B);
        drain("prefix_e1");
        exp_q.push_back({8'hAA, 1'b0, 1'b0});
        send_byte(8'hAA);
        drain("prefix_clear");
    endtask

    task automatic test_frame_err();
        int e0;
        e0 = err_seen;
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
        repeat (H) @(negedge clk);
        n_cmp++;
        if (err_seen - e0 != 1) begin n_fail++; $display("FAIL parity_err: got %0d pulses, required 1", err_seen - e0); end
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'h1C);
        drain("after_parity");
        e0 = err_seen;
        send_byte(8'hF0);
        send_bits(make_frame(8'h42, 1'b0, 1'b0), 11);
        repeat (H) @(negedge clk);
        n_cmp++;
        if (err_seen - e0 != 1) begin n_fail++; $display("FAIL stop_err: got %0d pulses, required 1", err_seen - e0); end
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'h1C);
        drain("err_clears_flags");
    endtask

    task automatic test_overflow();
        int o0;
        o0 = ovf_seen;
        set_ready(1'b0);
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'h1C);
        send_byte(8'h32);
        repeat (H) @(negedge clk);
        n_cmp += 3;
        if (ovf_seen - o0 != 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d, required 1", ovf_seen - o0); end
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b, required 1", key_valid); end
        if (key_code !== 8'h1C) begin n_fail++; $display("FAIL ovf_code: got %h, required 1C", key_code); end
        set_ready(1'b1);
        drain("overflow");
        @(negedge clk);
        n_cmp += 2;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_accept_valid: got %b, required 0", key_valid); end
        if (key_code !== 8'h1C) begin n_fail++; $display("FAIL ovf_hold_code: got %h, required 1C", key_code); end
    endtask

    task automatic test_latency();
        int lat;
        lat = 0;
        set_ready(1'b0);
        exp_q.push_back({8'h4D, 1'b0, 1'b0});
        send_bits(make_frame(8'h4D, 1'b0, 1'b1), 10);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (key_valid) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat == 0 || lat > int'(SYNC + FILT + 2)) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required 1..%0d", lat, SYNC + FILT + 2);
        end
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        set_ready(1'b1);
        drain("latency");
    endtask

    task automatic test_reset_mid();
        int e0;
        send_bits(make_frame(8'hE0, 1'b0, 1'b1), 5);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", key_valid); end
        rst_n = 1'b1;
        e0 = err_seen;
        exp_q.push_back({8'h29, 1'b0, 1'b0});
        send_byte(8'h29);
        drain("midrst");
        n_cmp++;
        if (err_seen != e0) begin n_fail++; $display("FAIL midrst_ferr: got %0d, required 0", err_seen - e0); end
    endtask

`ifdef PS2_TIMEOUT_EN
    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        send_bits(make_frame(8'h5A, 1'b0, 1'b1), 3);
        repeat (TO_CYC - 100) @(negedge clk);
        n_cmp++;
        if (err_seen != e0) begin n_fail++; $display("FAIL timeout_early: got %0d, required 0", err_seen - e0); end
        repeat (200) @(negedge clk);
        n_cmp++;
        if (err_seen - e0 != 1) begin n_fail++; $display("FAIL timeout_err: got %0d, required 1", err_seen - e0); end
        exp_q.push_back({8'h5A, 1'b0, 1'b0});
        send_byte(8'h5A);
        drain("timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_frame_err();
        test_overflow();
        test_latency();
        test_reset_mid();
`ifdef PS2_TIMEOUT_EN
        test_timeout();
`endif
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
